// File: rtl/titan_ex_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : titan_ex_stage_if
//  Description : Bundle of ID/EX inputs, EX/MEM register outputs and the EX
//                forwarding path for the Titan RV32 execute stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface titan_ex_stage_if;
    // Pipeline control
    logic        ex_stall_i;
    logic        ex_flush_i;

    // ID/EX payload
    logic [31:0] ex_pc_i;
    logic [31:0] ex_instruction_i;
    logic [31:0] ex_port_a_i;
    logic [31:0] ex_port_b_i;
    logic [31:0] ex_store_data_i;
    logic [3:0]  ex_alu_op_i;
    logic [4:0]  ex_waddr_i;
    logic        ex_we_i;
    logic [5:0]  ex_mem_flags_i;
    logic        ex_mem_ex_sel_i;
    logic        ex_illegal_inst_i;
    logic        ex_inst_addr_misaligned_i;
    logic        ex_inst_access_fault_i;
    logic        ex_fence_op_i;
    logic        ex_xret_op_i;
    logic        ex_break_op_i;
    logic        ex_syscall_op_i;
    logic [31:0] ex_csr_data_i;
    logic [2:0]  ex_csr_op_i;
    logic [11:0] ex_csr_addr_i;

    // Forwarding back to ID
    logic [31:0] ex_fwd_drd_o;

    // EX/MEM register
    logic [31:0] mem_pc_o;
    logic [31:0] mem_instruction_o;
    logic [31:0] mem_alu_result_o;
    logic [31:0] mem_store_data_o;
    logic [4:0]  mem_waddr_o;
    logic        mem_we_o;
    logic [5:0]  mem_mem_flags_o;
    logic        mem_mem_ex_sel_o;
    logic        mem_ld_misaligned_o;
    logic        mem_st_misaligned_o;
    logic        mem_illegal_inst_o;
    logic        mem_inst_addr_misaligned_o;
    logic        mem_inst_access_fault_o;
    logic        mem_fence_op_o;
    logic        mem_xret_op_o;
    logic        mem_break_op_o;
    logic        mem_syscall_op_o;
    logic [31:0] mem_csr_data_o;
    logic [2:0]  mem_csr_op_o;
    logic [11:0] mem_csr_addr_o;
    logic        mem_exception_o;

    // Producer side: the ID/EX register and pipeline control
    modport master (
        output ex_stall_i, ex_flush_i,
        output ex_pc_i, ex_instruction_i, ex_port_a_i, ex_port_b_i,
        output ex_store_data_i, ex_alu_op_i, ex_waddr_i, ex_we_i,
        output ex_mem_flags_i, ex_mem_ex_sel_i,
        output ex_illegal_inst_i, ex_inst_addr_misaligned_i,
        output ex_inst_access_fault_i, ex_fence_op_i, ex_xret_op_i,
        output ex_break_op_i, ex_syscall_op_i,
        output ex_csr_data_i, ex_csr_op_i, ex_csr_addr_i,
        input  ex_fwd_drd_o,
        input  mem_pc_o, mem_instruction_o, mem_alu_result_o,
        input  mem_store_data_o, mem_waddr_o, mem_we_o, mem_mem_flags_o,
        input  mem_mem_ex_sel_o, mem_ld_misaligned_o, mem_st_misaligned_o,
        input  mem_illegal_inst_o, mem_inst_addr_misaligned_o,
        input  mem_inst_access_fault_o, mem_fence_op_o, mem_xret_op_o,
        input  mem_break_op_o, mem_syscall_op_o,
        input  mem_csr_data_o, mem_csr_op_o, mem_csr_addr_o,
        input  mem_exception_o
    );

    // Execute stage side
    modport slave (
        input  ex_stall_i, ex_flush_i,
        input  ex_pc_i, ex_instruction_i, ex_port_a_i, ex_port_b_i,
        input  ex_store_data_i, ex_alu_op_i, ex_waddr_i, ex_we_i,
        input  ex_mem_flags_i, ex_mem_ex_sel_i,
        input  ex_illegal_inst_i, ex_inst_addr_misaligned_i,
        input  ex_inst_access_fault_i, ex_fence_op_i, ex_xret_op_i,
        input  ex_break_op_i, ex_syscall_op_i,
        input  ex_csr_data_i, ex_csr_op_i, ex_csr_addr_i,
        output ex_fwd_drd_o,
        output mem_pc_o, mem_instruction_o, mem_alu_result_o,
        output mem_store_data_o, mem_waddr_o, mem_we_o, mem_mem_flags_o,
        output mem_mem_ex_sel_o, mem_ld_misaligned_o, mem_st_misaligned_o,
        output mem_illegal_inst_o, mem_inst_addr_misaligned_o,
        output mem_inst_access_fault_o, mem_fence_op_o, mem_xret_op_o,
        output mem_break_op_o, mem_syscall_op_o,
        output mem_csr_data_o, mem_csr_op_o, mem_csr_addr_o,
        output mem_exception_o
    );
endinterface
`default_nettype wire

// File: rtl/titan_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : titan_ex_stage
//  Description : Titan RV32 execute stage. ALU, data-memory alignment check
//                and the EX/MEM pipeline register. The raw ALU result is
//                forwarded combinationally to the ID-stage operand muxes.
//  Revision    : 1.0 - initial release
// ============================================================================
module titan_ex_stage #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0200
) (
    input  logic             clk_i,
    input  logic             rst_i,
    titan_ex_stage_if.slave  ex_if
);

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    localparam logic [3:0] C_OP_ADD  = 4'd0;
    localparam logic [3:0] C_OP_SUB  = 4'd1;
    localparam logic [3:0] C_OP_SLL  = 4'd2;
    localparam logic [3:0] C_OP_SLT  = 4'd3;
    localparam logic [3:0] C_OP_SLTU = 4'd4;
    localparam logic [3:0] C_OP_XOR  = 4'd5;
    localparam logic [3:0] C_OP_SRL  = 4'd6;
    localparam logic [3:0] C_OP_SRA  = 4'd7;
    localparam logic [3:0] C_OP_OR   = 4'd8;
    localparam logic [3:0] C_OP_AND  = 4'd9;
    localparam logic [3:0] C_OP_PASS = 4'd10;

    localparam logic [1:0] C_SIZE_BYTE = 2'b00;
    localparam logic [1:0] C_SIZE_HALF = 2'b01;
    localparam logic [1:0] C_SIZE_WORD = 2'b10;

    // Full contents of the EX/MEM register
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [4:0]  waddr;
        logic        we;
        logic [5:0]  mem_flags;
        logic        mem_ex_sel;
        logic        ld_misaligned;
        logic        st_misaligned;
        logic        illegal_inst;
        logic        inst_addr_misaligned;
        logic        inst_access_fault;
        logic        fence_op;
        logic        xret_op;
        logic        break_op;
        logic        syscall_op;
        logic [31:0] csr_data;
        logic [2:0]  csr_op;
        logic [11:0] csr_addr;
        logic        exception;
    } ex_mem_t;

    // Bubble: a NOP at the reset vector with nothing enabled
    function automatic ex_mem_t bubble_f();
        ex_mem_t b;
        b             = '0;
        b.pc          = RESET_ADDR;
        b.instruction = C_NOP;
        return b;
    endfunction

    logic [31:0] w_alu_result;
    logic [4:0]  w_shamt;
    logic        w_mem_rd;
    logic        w_mem_wr;
    logic [1:0]  w_mem_size;
    logic        w_misaligned;
    ex_mem_t     mem_d;
    ex_mem_t     mem_q;

    assign w_shamt    = ex_if.ex_port_b_i[4:0];
    assign w_mem_rd   = ex_if.ex_mem_flags_i[0];
    assign w_mem_wr   = ex_if.ex_mem_flags_i[1];
    assign w_mem_size = ex_if.ex_mem_flags_i[4:3];

    // ALU: pure combinational, wraps modulo 2^32, unused codes give zero
    always_comb begin
        w_alu_result = '0;
        case (ex_if.ex_alu_op_i)
            C_OP_ADD:  w_alu_result = ex_if.ex_port_a_i + ex_if.ex_port_b_i;
            C_OP_SUB:  w_alu_result = ex_if.ex_port_a_i - ex_if.ex_port_b_i;
            C_OP_SLL:  w_alu_result = ex_if.ex_port_a_i << w_shamt;
            C_OP_SLT:  w_alu_result = {31'd0, $signed(ex_if.ex_port_a_i) < $signed(ex_if.ex_port_b_i)};
            C_OP_SLTU: w_alu_result = {31'd0, ex_if.ex_port_a_i < ex_if.ex_port_b_i};
            C_OP_XOR:  w_alu_result = ex_if.ex_port_a_i ^ ex_if.ex_port_b_i;
            C_OP_SRL:  w_alu_result = ex_if.ex_port_a_i >> w_shamt;
            C_OP_SRA:  w_alu_result = $unsigned($signed(ex_if.ex_port_a_i) >>> w_shamt);
            C_OP_OR:   w_alu_result = ex_if.ex_port_a_i | ex_if.ex_port_b_i;
            C_OP_AND:  w_alu_result = ex_if.ex_port_a_i & ex_if.ex_port_b_i;
            C_OP_PASS: w_alu_result = ex_if.ex_port_b_i;
            default:   w_alu_result = '0;
        endcase
    end

    // Forwarding path is taken straight from the ALU so it stays live under stall
    assign ex_if.ex_fwd_drd_o = w_alu_result;

    // Alignment: only real memory accesses can fault; size 11 is never legal
    always_comb begin
        w_misaligned = 1'b0;
        if (w_mem_rd || w_mem_wr) begin
            case (w_mem_size)
                C_SIZE_BYTE: w_misaligned = 1'b0;
                C_SIZE_HALF: w_misaligned = w_alu_result[0];
                C_SIZE_WORD: w_misaligned = |w_alu_result[1:0];
                default:     w_misaligned = 1'b1;
            endcase
        end
    end

    // Next EX/MEM contents; a faulting access loses its side effects
    always_comb begin
        mem_d                      = '0;
        mem_d.pc                   = ex_if.ex_pc_i;
        mem_d.instruction          = ex_if.ex_instruction_i;
        mem_d.alu_result           = w_alu_result;
        mem_d.store_data           = ex_if.ex_store_data_i;
        mem_d.waddr                = ex_if.ex_waddr_i;
        mem_d.we                   = ex_if.ex_we_i & ~w_misaligned;
        mem_d.mem_flags            = {ex_if.ex_mem_flags_i[5:2],
                                      ex_if.ex_mem_flags_i[1:0] & {2{~w_misaligned}}};
        mem_d.mem_ex_sel           = ex_if.ex_mem_ex_sel_i;
        mem_d.ld_misaligned        = w_misaligned & w_mem_rd;
        mem_d.st_misaligned        = w_misaligned & w_mem_wr;
        mem_d.illegal_inst         = ex_if.ex_illegal_inst_i;
        mem_d.inst_addr_misaligned = ex_if.ex_inst_addr_misaligned_i;
        mem_d.inst_access_fault    = ex_if.ex_inst_access_fault_i;
        mem_d.fence_op             = ex_if.ex_fence_op_i;
        mem_d.xret_op              = ex_if.ex_xret_op_i;
        mem_d.break_op             = ex_if.ex_break_op_i;
        mem_d.syscall_op           = ex_if.ex_syscall_op_i;
        mem_d.csr_data             = ex_if.ex_csr_data_i;
        mem_d.csr_op               = ex_if.ex_csr_op_i;
        mem_d.csr_addr             = ex_if.ex_csr_addr_i;
        // fence and xret are ordinary system ops, not traps
        mem_d.exception            = ex_if.ex_illegal_inst_i
                                   | ex_if.ex_inst_addr_misaligned_i
                                   | ex_if.ex_inst_access_fault_i
                                   | ex_if.ex_break_op_i
                                   | ex_if.ex_syscall_op_i
                                   | (w_misaligned & (w_mem_rd | w_mem_wr));
    end

    // EX/MEM register: async reset, then flush, then stall, then load
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q <= bubble_f();
        end else if (ex_if.ex_flush_i) begin
            mem_q <= bubble_f();
        end else if (!ex_if.ex_stall_i) begin
            mem_q <= mem_d;
        end
    end

    assign ex_if.mem_pc_o                   = mem_q.pc;
    assign ex_if.mem_instruction_o          = mem_q.instruction;
    assign ex_if.mem_alu_result_o           = mem_q.alu_result;
    assign ex_if.mem_store_data_o           = mem_q.store_data;
    assign ex_if.mem_waddr_o                = mem_q.waddr;
    assign ex_if.mem_we_o                   = mem_q.we;
    assign ex_if.mem_mem_flags_o            = mem_q.mem_flags;
    assign ex_if.mem_mem_ex_sel_o           = mem_q.mem_ex_sel;
    assign ex_if.mem_ld_misaligned_o        = mem_q.ld_misaligned;
    assign ex_if.mem_st_misaligned_o        = mem_q.st_misaligned;
    assign ex_if.mem_illegal_inst_o         = mem_q.illegal_inst;
    assign ex_if.mem_inst_addr_misaligned_o = mem_q.inst_addr_misaligned;
    assign ex_if.mem_inst_access_fault_o    = mem_q.inst_access_fault;
    assign ex_if.mem_fence_op_o             = mem_q.fence_op;
    assign ex_if.mem_xret_op_o              = mem_q.xret_op;
    assign ex_if.mem_break_op_o             = mem_q.break_op;
    assign ex_if.mem_syscall_op_o           = mem_q.syscall_op;
    assign ex_if.mem_csr_data_o             = mem_q.csr_data;
    assign ex_if.mem_csr_op_o               = mem_q.csr_op;
    assign ex_if.mem_csr_addr_o             = mem_q.csr_addr;
    assign ex_if.mem_exception_o            = mem_q.exception;

endmodule
`default_nettype wire

// File: tb/tb_titan_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_titan_ex_stage
//  Description : Self-checking bench for titan_ex_stage: directed corner
//                cases followed by randomized traffic against a behavioural
//                model of the execute stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_titan_ex_stage;

    localparam logic [31:0] RESET_ADDR = 32'h0000_0200;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    titan_ex_stage_if bus ();

    titan_ex_stage #(.RESET_ADDR(RESET_ADDR)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .ex_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected EX/MEM contents
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] res;
        logic [31:0] sd;
        logic [4:0]  waddr;
        logic        we;
        logic [5:0]  flags;
        logic        sel;
        logic        ldm;
        logic        stm;
        logic        ill;
        logic        iam;
        logic        iaf;
        logic        fence;
        logic        xret;
        logic        brk;
        logic        sys;
        logic [31:0] csrd;
        logic [2:0]  csrop;
        logic [11:0] csra;
        logic        exc;
    } exp_t;

    exp_t exp_q;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic exp_t model_bubble();
        exp_t b;
        b       = '0;
        b.pc    = RESET_ADDR;
        b.instr = 32'h0000_0013;
        return b;
    endfunction

    // Reference ALU written arithmetically rather than with shift operators
    function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] p2;
        logic [31:0] srl;
        p2  = 32'd1 << (b % 32);
        srl = a / p2;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a + (~b) + 32'd1;
            4'd2:  return a * p2;
            4'd3:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'd4:  return (a < b) ? 32'd1 : 32'd0;
            4'd5:  return a ^ b;
            4'd6:  return srl;
            4'd7:  return a[31] ? (srl | ~(32'hFFFF_FFFF / p2)) : srl;
            4'd8:  return a | b;
            4'd9:  return a & b;
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    // Next expected register contents given the inputs currently on the bus
    function automatic exp_t model_next(input exp_t cur);
        exp_t        n;
        logic [31:0] r;
        int unsigned bytes;
        logic        rd;
        logic        wr;
        logic        mis;
        if (bus.ex_flush_i) return model_bubble();
        if (bus.ex_stall_i) return cur;
        r  = model_alu(bus.ex_alu_op_i, bus.ex_port_a_i, bus.ex_port_b_i);
        rd = bus.ex_mem_flags_i[0];
        wr = bus.ex_mem_flags_i[1];
        case (bus.ex_mem_flags_i[4:3])
            2'b00:   bytes = 1;
            2'b01:   bytes = 2;
            2'b10:   bytes = 4;
            default: bytes = 0;
        endcase
        mis     = (rd || wr) && (bytes == 0 || (r % bytes) != 0);
        n.pc    = bus.ex_pc_i;
        n.instr = bus.ex_instruction_i;
        n.res   = r;
        n.sd    = bus.ex_store_data_i;
        n.waddr = bus.ex_waddr_i;
        n.we    = bus.ex_we_i && !mis;
        n.flags = mis ? {bus.ex_mem_flags_i[5:2], 2'b00} : bus.ex_mem_flags_i;
        n.sel   = bus.ex_mem_ex_sel_i;
        n.ldm   = mis && rd;
        n.stm   = mis && wr;
        n.ill   = bus.ex_illegal_inst_i;
        n.iam   = bus.ex_inst_addr_misaligned_i;
        n.iaf   = bus.ex_inst_access_fault_i;
        n.fence = bus.ex_fence_op_i;
        n.xret  = bus.ex_xret_op_i;
        n.brk   = bus.ex_break_op_i;
        n.sys   = bus.ex_syscall_op_i;
        n.csrd  = bus.ex_csr_data_i;
        n.csrop = bus.ex_csr_op_i;
        n.csra  = bus.ex_csr_addr_i;
        n.exc   = n.ill || n.iam || n.iaf || n.brk || n.sys || n.ldm || n.stm;
        return n;
    endfunction

    task automatic compare_all(input string ctx);
        check_val({ctx, ".pc"},     bus.mem_pc_o,                   exp_q.pc);
        check_val({ctx, ".instr"},  bus.mem_instruction_o,          exp_q.instr);
        check_val({ctx, ".res"},    bus.mem_alu_result_o,           exp_q.res);
        check_val({ctx, ".sd"},     bus.mem_store_data_o,           exp_q.sd);
        check_val({ctx, ".waddr"},  32'(bus.mem_waddr_o),           32'(exp_q.waddr));
        check_val({ctx, ".we"},     32'(bus.mem_we_o),              32'(exp_q.we));
        check_val({ctx, ".flags"},  32'(bus.mem_mem_flags_o),       32'(exp_q.flags));
        check_val({ctx, ".sel"},    32'(bus.mem_mem_ex_sel_o),      32'(exp_q.sel));
        check_val({ctx, ".ldm"},    32'(bus.mem_ld_misaligned_o),   32'(exp_q.ldm));
        check_val({ctx, ".stm"},    32'(bus.mem_st_misaligned_o),   32'(exp_q.stm));
        check_val({ctx, ".sysflg"}, {25'd0, bus.mem_illegal_inst_o, bus.mem_inst_addr_misaligned_o,
                                     bus.mem_inst_access_fault_o, bus.mem_fence_op_o, bus.mem_xret_op_o,
                                     bus.mem_break_op_o, bus.mem_syscall_op_o},
                                    {25'd0, exp_q.ill, exp_q.iam, exp_q.iaf, exp_q.fence, exp_q.xret,
                                     exp_q.brk, exp_q.sys});
        check_val({ctx, ".csrd"},   bus.mem_csr_data_o,             exp_q.csrd);
        check_val({ctx, ".csr"},    {17'd0, bus.mem_csr_op_o, bus.mem_csr_addr_o},
                                    {17'd0, exp_q.csrop, exp_q.csra});
        check_val({ctx, ".exc"},    32'(bus.mem_exception_o),       32'(exp_q.exc));
    endtask

    task automatic set_idle();
        bus.ex_stall_i                = 1'b0;
        bus.ex_flush_i                = 1'b0;
        bus.ex_pc_i                   = 32'h0000_1000;
        bus.ex_instruction_i          = 32'h0000_0033;
        bus.ex_port_a_i               = '0;
        bus.ex_port_b_i               = '0;
        bus.ex_store_data_i           = '0;
        bus.ex_alu_op_i               = '0;
        bus.ex_waddr_i                = '0;
        bus.ex_we_i                   = 1'b0;
        bus.ex_mem_flags_i            = '0;
        bus.ex_mem_ex_sel_i           = 1'b0;
        bus.ex_illegal_inst_i         = 1'b0;
        bus.ex_inst_addr_misaligned_i = 1'b0;
        bus.ex_inst_access_fault_i    = 1'b0;
        bus.ex_fence_op_i             = 1'b0;
        bus.ex_xret_op_i              = 1'b0;
        bus.ex_break_op_i             = 1'b0;
        bus.ex_syscall_op_i           = 1'b0;
        bus.ex_csr_data_i             = '0;
        bus.ex_csr_op_i               = '0;
        bus.ex_csr_addr_i             = '0;
    endtask

    task automatic set_random();
        bus.ex_stall_i                = ($urandom_range(0, 3) == 0);
        bus.ex_flush_i                = ($urandom_range(0, 9) == 0);
        bus.ex_pc_i                   = $urandom;
        bus.ex_instruction_i          = $urandom;
        bus.ex_port_a_i               = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
        bus.ex_port_b_i               = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        bus.ex_store_data_i           = $urandom;
        bus.ex_alu_op_i               = 4'($urandom_range(0, 15));
        bus.ex_waddr_i                = 5'($urandom);
        bus.ex_we_i                   = 1'($urandom);
        bus.ex_mem_flags_i            = 6'($urandom);
        bus.ex_mem_ex_sel_i           = 1'($urandom);
        bus.ex_illegal_inst_i         = ($urandom_range(0, 15) == 0);
        bus.ex_inst_addr_misaligned_i = ($urandom_range(0, 15) == 0);
        bus.ex_inst_access_fault_i    = ($urandom_range(0, 15) == 0);
        bus.ex_fence_op_i             = ($urandom_range(0, 7) == 0);
        bus.ex_xret_op_i              = ($urandom_range(0, 7) == 0);
        bus.ex_break_op_i             = ($urandom_range(0, 15) == 0);
        bus.ex_syscall_op_i           = ($urandom_range(0, 15) == 0);
        bus.ex_csr_data_i             = $urandom;
        bus.ex_csr_op_i               = 3'($urandom);
        bus.ex_csr_addr_i             = 12'($urandom);
    endtask

    // Inputs are already driven (just after a falling edge): check the
    // forwarding path, advance one rising edge, check the register.
    task automatic step(input string ctx);
        exp_t nxt;
        #1;
        check_val({ctx, ".fwd"}, bus.ex_fwd_drd_o,
                  model_alu(bus.ex_alu_op_i, bus.ex_port_a_i, bus.ex_port_b_i));
        nxt = model_next(exp_q);
        @(posedge clk);
        exp_q = nxt;
        #1;
        compare_all(ctx);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        set_idle();
        exp_q = model_bubble();
        repeat (2) @(negedge clk);
        compare_all("reset");
        rst = 1'b0;

        // ALU corners
        bus.ex_alu_op_i = 4'd1; bus.ex_port_a_i = 32'd0; bus.ex_port_b_i = 32'd1;
        #1 check_val("sub_wrap", bus.ex_fwd_drd_o, 32'hFFFF_FFFF);
        step("sub");
        bus.ex_alu_op_i = 4'd7; bus.ex_port_a_i = 32'h8000_0000; bus.ex_port_b_i = 32'd31;
        #1 check_val("sra31", bus.ex_fwd_drd_o, 32'hFFFF_FFFF);
        step("sra");
        bus.ex_alu_op_i = 4'd3; bus.ex_port_a_i = 32'hFFFF_FFFF; bus.ex_port_b_i = 32'd1;
        #1 check_val("slt_neg", bus.ex_fwd_drd_o, 32'd1);
        step("slt");
        bus.ex_alu_op_i = 4'd4;
        #1 check_val("sltu_neg", bus.ex_fwd_drd_o, 32'd0);
        step("sltu");

        // Misaligned word load kills write-back and read
        bus.ex_alu_op_i = 4'd10; bus.ex_port_b_i = 32'h0000_1002;
        bus.ex_mem_flags_i = 6'b010001; bus.ex_we_i = 1'b1; bus.ex_waddr_i = 5'd9;
        step("ldmis");
        check_val("ldmis_flag", 32'(bus.mem_ld_misaligned_o), 32'd1);
        check_val("ldmis_exc",  32'(bus.mem_exception_o),     32'd1);
        check_val("ldmis_we",   32'(bus.mem_we_o),            32'd0);
        check_val("ldmis_rd",   32'(bus.mem_mem_flags_o[0]),  32'd0);

        // Half store at a half-aligned address is fine
        bus.ex_mem_flags_i = 6'b001010; bus.ex_we_i = 1'b0;
        step("sthalf");
        check_val("sthalf_stm", 32'(bus.mem_st_misaligned_o), 32'd0);
        check_val("sthalf_wr",  32'(bus.mem_mem_flags_o[1]),  32'd1);

        // Valid instruction, hold it for three cycles, then stall+flush
        bus.ex_mem_flags_i = '0; bus.ex_alu_op_i = 4'd0;
        bus.ex_port_a_i = 32'h0000_0100; bus.ex_port_b_i = 32'h0000_0023;
        bus.ex_we_i = 1'b1; bus.ex_waddr_i = 5'd5; bus.ex_pc_i = 32'h0000_3000;
        step("load");
        bus.ex_stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.ex_pc_i = bus.ex_pc_i + 32'd4;
            bus.ex_port_a_i = $urandom;
            step("stall");
        end
        check_val("stall_hold", bus.mem_alu_result_o, 32'h0000_0123);
        bus.ex_flush_i = 1'b1;
        step("stflush");
        check_val("stflush_pc", bus.mem_pc_o, 32'h0000_0200);

        // Syscall is a trap; flushed it leaves nothing behind
        set_idle();
        bus.ex_syscall_op_i = 1'b1;
        step("sys");
        check_val("sys_exc", {31'd0, bus.mem_exception_o}, 32'd1);
        bus.ex_flush_i = 1'b1;
        step("sysflush");
        check_val("sysflush_exc", {30'd0, bus.mem_syscall_op_o, bus.mem_exception_o}, 32'd0);

        // Forwarding while stalled
        set_idle();
        bus.ex_alu_op_i = 4'd10; bus.ex_port_b_i = 32'hABCD_0000;
        step("pre_fwd");
        bus.ex_stall_i = 1'b1; bus.ex_alu_op_i = 4'd0;
        bus.ex_port_a_i = 32'd5; bus.ex_port_b_i = 32'd7;
        #1 check_val("fwd_stall", bus.ex_fwd_drd_o, 32'd12);
        step("fwd");
        check_val("fwd_hold", bus.mem_alu_result_o, 32'hABCD_0000);

        // Asynchronous reset mid-stall, then a normal first load
        #2 rst = 1'b1;
        exp_q = model_bubble();
        #1 compare_all("areset");
        check_val("areset_pc", bus.mem_pc_o, 32'h0000_0200);
        @(negedge clk);
        rst = 1'b0;
        set_idle();
        bus.ex_alu_op_i = 4'd0; bus.ex_port_a_i = 32'd40; bus.ex_port_b_i = 32'd2;
        bus.ex_we_i = 1'b1;
        step("post_rst");
        check_val("post_rst_res", bus.mem_alu_result_o, 32'd42);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_random();
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Guard against a stuck run
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
